toffoli_cascade_seq: RTL

Sequencer that applies a programmed cascade of Toffoli (CCNOT) gates to a WIDTH-bit reversible state register, one gate per clock, through a single shared Toffoli datapath (P=A, Q=B, R=(A&B)^C). It holds a small gate program (control1, control2, target per entry) and runs it forward, or in reverse order to uncompute. It sits between a host that loads programs and operands and the reversible-logic datapath. Because every Toffoli gate is self-inverse, a reverse run exactly undoes a forward run.

---
 rtl/toffoli_cascade_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/toffoli_cascade_seq.sv
// toffoli_cascade_seq: runs a programmed Toffoli cascade on a reversible
// state register, one gate per clock, in forward or reverse order.
module toffoli_cascade_seq #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int IW    = $clog2(WIDTH),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [IW-1:0]    prog_c1,
    input  logic [IW-1:0]    prog_c2,
    input  logic [IW-1:0]    prog_t,
    input  logic [AW:0]      num_gates,
    input  logic             reverse,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int SW = 1 << IW;
    localparam int EW = 3 * IW;

    function automatic logic [SW-1:0] idx_ok_mask();
        logic [SW-1:0] m;
        m = '0;
        for (int i = 0; i < SW; i++) m[i] = (i < WIDTH);
        return m;
    endfunction

    // Index codes that name a real state bit (all of them for pow2 WIDTH).
    localparam logic [SW-1:0] IDX_OK = idx_ok_mask();

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic [AW:0]      rem_q, rem_d;
    logic             rev_q, rev_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [EW-1:0]    prog_mem_q [DEPTH];

    logic [EW-1:0]    entry;
    logic [IW-1:0]    g_c1, g_c2, g_t;
    logic [SW-1:0]    ext, gated;
    logic             illegal;
    logic             tof_r;
    logic [AW:0]      n_clamp;

    // Program store; host writes are only accepted while idle.
    always_ff @(posedge clk) begin
        if (prog_we && !busy_q) begin
            prog_mem_q[prog_addr] <= {prog_c1, prog_c2, prog_t};
        end
    end

    // Shared Toffoli datapath on the entry addressed by pc.
    always_comb begin
        entry   = prog_mem_q[pc_q];
        g_c1    = entry[EW-1 -: IW];
        g_c2    = entry[2*IW-1 -: IW];
        g_t     = entry[IW-1:0];
        ext     = '0;
        ext[WIDTH-1:0] = state_q;
        illegal = (g_t == g_c1) || (g_t == g_c2) ||
                  !IDX_OK[g_c1] || !IDX_OK[g_c2] || !IDX_OK[g_t];
        tof_r   = (ext[g_c1] & ext[g_c2]) ^ ext[g_t];
        gated   = ext;
        gated[g_t] = tof_r;
    end

    // Sequencer next-state: start capture, gate stepping, completion.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        pc_d    = pc_q;
        rem_d   = rem_q;
        rev_d   = rev_q;
        err_d   = err_q;
        n_clamp = (num_gates > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_gates;
        unique case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    state_d = data_in;
                    rev_d   = reverse;
                    err_d   = 1'b0;
                    rem_d   = n_clamp;
                    pc_d    = reverse ? AW'(n_clamp - 1'b1) : '0;
                    fsm_d   = (n_clamp == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (illegal) begin
                    err_d = 1'b1;
                end else begin
                    state_d = gated[WIDTH-1:0];
                end
                pc_d  = rev_q ? pc_q - AW'(1) : pc_q + AW'(1);
                rem_d = rem_q - 1'b1;
                if (rem_q == (AW+1)'(1)) fsm_d = S_DONE;
            end
            S_DONE: begin
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
        busy_d = (fsm_d != S_IDLE);
        done_d = (fsm_d == S_DONE);
    end

    // Sequencer registers with asynchronous abort to the reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            pc_q    <= '0;
            rem_q   <= '0;
            rev_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            pc_q    <= pc_d;
            rem_q   <= rem_d;
            rev_q   <= rev_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out = state_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
